decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 57 +++++
 rtl/decode_stage_reg_file.sv | 33 +++
 rtl/decode_stage.sv | 117 +++++++++++
 tb/tb_decode_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared processor definitions for the decode stage: opcodes, immediate formats
// and the layout of the ID pipeline register.
package decode_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_REG    = 7'h33;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            illegal;
   } id_regs_t;

   function automatic imm_type_e imm_type_of(input logic [6:0] op);
      case (op)
         OP_IMM, OP_LOAD, OP_JALR: imm_type_of = IMM_I;
         OP_STORE:                 imm_type_of = IMM_S;
         OP_BRANCH:                imm_type_of = IMM_B;
         OP_LUI, OP_AUIPC:         imm_type_of = IMM_U;
         OP_JAL:                   imm_type_of = IMM_J;
         default:                  imm_type_of = IMM_NONE;
      endcase
   endfunction

   // R-type has no immediate but is still a supported instruction.
   function automatic logic opcode_legal(input logic [6:0] op);
      opcode_legal = (op == OP_REG) || (imm_type_of(op) != IMM_NONE);
   endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, synchronous clear.
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: one pipeline register holding decoded fields,
// immediate and operands, with write-back bypass on capture and while stalled.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr_if,
   input  logic [XLEN-1:0] pc_if,
   input  logic            valid_if,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ready_id,
   output logic            valid_id,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] imm_id,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [4:0]      rs1_id,
   output logic [4:0]      rs2_id,
   output logic [4:0]      rd_id,
   output logic [6:0]      opcode_id,
   output logic [2:0]      funct3_id,
   output logic [6:0]      funct7_id,
   output logic            illegal_id
);
   import decode_stage_pkg::*;

   id_regs_t        id_q, id_d;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;
   logic [XLEN-1:0] imm_d;
   logic            wb_hit;
   logic [6:0]      op;

   assign op     = instr_if[6:0];
   assign wb_hit = wb_we && (wb_rd != 5'd0);

   reg_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_we && !rst),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (instr_if[19:15]),
      .raddr2 (instr_if[24:20]),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   always_comb begin
      imm_d = '0;
      case (imm_type_of(op))
         IMM_I:   imm_d = {{20{instr_if[31]}}, instr_if[31:20]};
         IMM_S:   imm_d = {{20{instr_if[31]}}, instr_if[31:25], instr_if[11:7]};
         IMM_B:   imm_d = {{19{instr_if[31]}}, instr_if[31], instr_if[7],
                           instr_if[30:25], instr_if[11:8], 1'b0};
         IMM_U:   imm_d = {instr_if[31:12], 12'd0};
         IMM_J:   imm_d = {{11{instr_if[31]}}, instr_if[31], instr_if[19:12],
                           instr_if[20], instr_if[30:21], 1'b0};
         default: imm_d = '0;
      endcase
   end

   // flush beats stall; a stalled stage still tracks write-backs to its operands.
   always_comb begin
      id_d = id_q;
      if (flush) begin
         id_d = '0;
      end else if (stall) begin
         if (wb_hit && (id_q.rs1 == wb_rd)) id_d.rs1_data = wb_data;
         if (wb_hit && (id_q.rs2 == wb_rd)) id_d.rs2_data = wb_data;
      end else begin
         id_d.valid    = valid_if;
         id_d.pc       = pc_if;
         id_d.imm      = imm_d;
         id_d.rs1      = instr_if[19:15];
         id_d.rs2      = instr_if[24:20];
         id_d.rd       = instr_if[11:7];
         id_d.opcode   = op;
         id_d.funct3   = instr_if[14:12];
         id_d.funct7   = instr_if[31:25];
         id_d.illegal  = !opcode_legal(op);
         id_d.rs1_data = (wb_hit && (wb_rd == instr_if[19:15])) ? wb_data : rf_rdata1;
         id_d.rs2_data = (wb_hit && (wb_rd == instr_if[24:20])) ? wb_data : rf_rdata2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_q <= '0;
      end else begin
         id_q <= id_d;
      end
   end

   assign ready_id   = !stall;
   assign valid_id   = id_q.valid;
   assign pc_id      = id_q.pc;
   assign imm_id     = id_q.imm;
   assign rs1_data   = id_q.rs1_data;
   assign rs2_data   = id_q.rs2_data;
   assign rs1_id     = id_q.rs1;
   assign rs2_id     = id_q.rs2;
   assign rd_id      = id_q.rd;
   assign opcode_id  = id_q.opcode;
   assign funct3_id  = id_q.funct3;
   assign funct7_id  = id_q.funct7;
   assign illegal_id = id_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, valid_if, stall, flush, wb_we;
   logic [31:0] instr_if, pc_if, wb_data;
   logic [4:0]  wb_rd;
   logic        ready_id, valid_id, illegal_id;
   logic [31:0] pc_id, imm_id, rs1_data, rs2_data;
   logic [4:0]  rs1_id, rs2_id, rd_id;
   logic [6:0]  opcode_id, funct7_id;
   logic [2:0]  funct3_id;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_if   (instr_if),
      .pc_if      (pc_if),
      .valid_if   (valid_if),
      .stall      (stall),
      .flush      (flush),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .ready_id   (ready_id),
      .valid_id   (valid_id),
      .pc_id      (pc_id),
      .imm_id     (imm_id),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .rs1_id     (rs1_id),
      .rs2_id     (rs2_id),
      .rd_id      (rd_id),
      .opcode_id  (opcode_id),
      .funct3_id  (funct3_id),
      .funct7_id  (funct7_id),
      .illegal_id (illegal_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b1; flush = 1'b0; valid_if = 1'b0;
      instr_if = 32'h0; pc_if = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
      tick();
      check("rst_ready_follows_stall", {31'd0, ready_id}, 32'd0);
      stall = 1'b0; #1;
      check("rst_ready_unstalled", {31'd0, ready_id}, 32'd1);
      tick();
      check("rst_valid", {31'd0, valid_id}, 32'd0);
      check("rst_pc", pc_id, 32'd0);
      check("rst_imm", imm_id, 32'd0);
      rst = 1'b0;

      // addi x1,x0,5
      instr_if = 32'h00500093; pc_if = 32'h0; valid_if = 1'b1;
      tick();
      check("addi_valid", {31'd0, valid_id}, 32'd1);
      check("addi_opcode", {25'd0, opcode_id}, 32'h13);
      check("addi_rd", {27'd0, rd_id}, 32'd1);
      check("addi_rs1", {27'd0, rs1_id}, 32'd0);
      check("addi_imm", imm_id, 32'd5);
      check("addi_rs1_data", rs1_data, 32'd0);
      check("addi_pc", pc_id, 32'd0);
      check("addi_illegal", {31'd0, illegal_id}, 32'd0);

      // add x3,x2,x2 with same-cycle write-back of x2
      instr_if = 32'h002101B3; pc_if = 32'h4;
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
      tick();
      check("byp_rs1_data", rs1_data, 32'hDEADBEEF);
      check("byp_rs2_data", rs2_data, 32'hDEADBEEF);
      check("byp_rd", {27'd0, rd_id}, 32'd3);
      check("byp_imm", imm_id, 32'd0);
      check("byp_opcode", {25'd0, opcode_id}, 32'h33);
      wb_we = 1'b0;

      // capture addi then stall three cycles with writes to x0
      instr_if = 32'h00500093; pc_if = 32'h8;
      tick();
      check("stall_pre_imm", imm_id, 32'd5);
      stall = 1'b1; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
      instr_if = 32'hFFF00113; pc_if = 32'h100;
      #1;
      check("stall_ready", {31'd0, ready_id}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         instr_if = instr_if + 32'h1000;
         tick();
         check("stall_hold_pc", pc_id, 32'h8);
         check("stall_hold_imm", imm_id, 32'd5);
         check("stall_hold_rs1_data", rs1_data, 32'd0);
         check("stall_hold_rd", {27'd0, rd_id}, 32'd1);
      end
      wb_rd = 5'd1; wb_data = 32'h77;
      tick();
      check("stall_wb_rd1_irrelevant", rs1_data, 32'd0);
      check("stall_rs1_id", {27'd0, rs1_id}, 32'd0);

      // add x3,x2,x2 reads x2 from the file, then stalled write-back of x2
      stall = 1'b0; wb_we = 1'b0;
      instr_if = 32'h002101B3; pc_if = 32'hC;
      tick();
      check("rf_read_x2", rs1_data, 32'hDEADBEEF);
      stall = 1'b1; wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
      tick();
      check("stall_byp_rs1", rs1_data, 32'h55);
      check("stall_byp_rs2", rs2_data, 32'h55);
      check("stall_byp_pc", pc_id, 32'hC);
      wb_we = 1'b0;
      tick();
      check("stall_byp_keep", rs1_data, 32'h55);

      // beq x0,x0,-8 then flush together with stall
      stall = 1'b0;
      instr_if = 32'hFE000CE3; pc_if = 32'h20;
      tick();
      check("beq_imm", imm_id, 32'hFFFFFFF8);
      check("beq_opcode", {25'd0, opcode_id}, 32'h63);
      flush = 1'b1; stall = 1'b1;
      tick();
      check("flush_valid", {31'd0, valid_id}, 32'd0);
      check("flush_imm", imm_id, 32'd0);
      check("flush_pc", pc_id, 32'd0);
      check("flush_opcode", {25'd0, opcode_id}, 32'd0);
      check("flush_funct7", {25'd0, funct7_id}, 32'd0);
      flush = 1'b0; stall = 1'b0;

      // write x0 then decode add x3,x0,x0
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
      instr_if = 32'h000001B3; pc_if = 32'h24;
      tick();
      check("x0_bypass_blocked", rs1_data, 32'd0);
      wb_we = 1'b0;
      tick();
      check("x0_rs1_data", rs1_data, 32'd0);
      check("x0_rs2_data", rs2_data, 32'd0);

      // other immediate formats and illegal / invalid cases
      instr_if = 32'h0020A223; // sw x2,4(x1)
      tick();
      check("s_imm", imm_id, 32'd4);
      check("s_funct3", {29'd0, funct3_id}, 32'd2);
      instr_if = 32'h123452B7; // lui x5,0x12345
      tick();
      check("u_imm", imm_id, 32'h12345000);
      instr_if = 32'hFF9FF06F; // jal x0,-8
      tick();
      check("j_imm", imm_id, 32'hFFFFFFF8);
      instr_if = 32'hFFF00093; // addi x1,x0,-1
      tick();
      check("i_neg_imm", imm_id, 32'hFFFFFFFF);
      instr_if = 32'hFFFFF07F;
      tick();
      check("illegal_flag", {31'd0, illegal_id}, 32'd1);
      check("illegal_imm", imm_id, 32'd0);
      check("illegal_valid", {31'd0, valid_id}, 32'd1);
      valid_if = 1'b0; instr_if = 32'h00500093;
      tick();
      check("novalid_valid", {31'd0, valid_id}, 32'd0);
      check("novalid_opcode", {25'd0, opcode_id}, 32'h13);

      // mid-stream reset while stalled clears outputs and the register file
      valid_if = 1'b1; instr_if = 32'h002101B3; pc_if = 32'h40;
      tick();
      check("pre_rst_x2", rs1_data, 32'h55);
      rst = 1'b1; stall = 1'b1; wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h99;
      tick();
      check("midrst_valid", {31'd0, valid_id}, 32'd0);
      check("midrst_pc", pc_id, 32'd0);
      check("midrst_rs1_data", rs1_data, 32'd0);
      check("midrst_rd", {27'd0, rd_id}, 32'd0);
      rst = 1'b0; stall = 1'b0; wb_we = 1'b0;
      tick();
      check("post_rst_x2_cleared", rs1_data, 32'd0);
      check("post_rst_valid", {31'd0, valid_id}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
